// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential single-precision adder.
package fp_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] mant;
    } float32_t;

    typedef enum logic [2:0] {
        StIdle,
        StSwap,
        StAlign,
        StAdd,
        StNorm,
        StOut
    } fp_state_t;

    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int unsigned MANT_W  = 24;

    // Exponent 0 is treated as zero, so the hidden bit is only set for exp != 0.
    function automatic logic [MANT_W-1:0] full_mant(float32_t f);
        return {(f.exp != 8'h00), f.mant};
    endfunction

endpackage

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for fp_add_seq.
interface fp_add_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        zero;
    logic        busy;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, overflow, zero, busy
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, overflow, zero, busy
    );
endinterface

// File: rtl/fp_align_shift.sv
// Combinational mantissa aligner: logical right shift, zero for shifts past the width.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] mant_i,
    input  logic [7:0]        shamt_i,
    output logic [MANT_W-1:0] mant_o
);

    // Truncating shift; shifted-out bits are dropped.
    always_comb begin
        mant_o = (shamt_i >= 8'(MANT_W)) ? '0 : (mant_i >> shamt_i);
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision add/sub: swap, align, add, iterative normalize.
module fp_add_seq
    import fp_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    fp_add_seq_if.slave bus
);

    fp_state_t   state_q, state_d;
    float32_t    op_a_q, op_a_d;
    float32_t    op_b_q, op_b_d;
    logic        sign_q, sign_d;
    logic        sign_men_q, sign_men_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  diff_q, diff_d;
    logic [23:0] mant_may_q, mant_may_d;
    logic [23:0] mant_men_q, mant_men_d;
    logic [24:0] sum_q, sum_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        zero_q, zero_d;
    logic        out_valid_q, out_valid_d;
    logic [23:0] men_shifted;
    logic [7:0]  exp_inc;

    fp_align_shift u_align (
        .mant_i  (mant_men_q),
        .shamt_i (diff_q),
        .mant_o  (men_shifted)
    );

    assign exp_inc       = exp_q + 8'd1;
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;

    // Next-state and datapath sequencing, one phase per state.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sign_d      = sign_q;
        sign_men_d  = sign_men_q;
        exp_d       = exp_q;
        diff_d      = diff_q;
        mant_may_d  = mant_may_q;
        mant_men_d  = mant_men_q;
        sum_d       = sum_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_a_d  = bus.a;
                    op_b_d  = {bus.b[31] ^ bus.sub, bus.b[30:0]};
                    state_d = StSwap;
                end
            end
            StSwap: begin
                if (op_a_q.exp == EXP_MAX || op_b_q.exp == EXP_MAX) begin
                    result_d    = QNAN;
                    overflow_d  = 1'b0;
                    zero_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    // Ties keep a as the larger operand.
                    if ({op_a_q.exp, op_a_q.mant} >= {op_b_q.exp, op_b_q.mant}) begin
                        sign_d     = op_a_q.sign;
                        sign_men_d = op_b_q.sign;
                        exp_d      = op_a_q.exp;
                        diff_d     = op_a_q.exp - op_b_q.exp;
                        mant_may_d = full_mant(op_a_q);
                        mant_men_d = full_mant(op_b_q);
                    end else begin
                        sign_d     = op_b_q.sign;
                        sign_men_d = op_a_q.sign;
                        exp_d      = op_b_q.exp;
                        diff_d     = op_b_q.exp - op_a_q.exp;
                        mant_may_d = full_mant(op_b_q);
                        mant_men_d = full_mant(op_a_q);
                    end
                    state_d = StAlign;
                end
            end
            StAlign: begin
                mant_men_d = men_shifted;
                state_d    = StAdd;
            end
            StAdd: begin
                // Larger magnitude minus smaller can never go negative.
                if (sign_q == sign_men_q) begin
                    sum_d = {1'b0, mant_may_q} + {1'b0, mant_men_q};
                end else begin
                    sum_d = {1'b0, mant_may_q} - {1'b0, mant_men_q};
                end
                if (sum_d == '0) begin
                    result_d    = '0;
                    overflow_d  = 1'b0;
                    zero_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (sum_q[24]) begin
                    zero_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                    if (exp_inc == EXP_MAX) begin
                        result_d   = {sign_q, EXP_MAX, 23'd0};
                        overflow_d = 1'b1;
                    end else begin
                        result_d   = {sign_q, exp_inc, sum_q[23:1]};
                        overflow_d = 1'b0;
                    end
                end else if (sum_q[23]) begin
                    result_d    = {sign_q, exp_q, sum_q[22:0]};
                    overflow_d  = 1'b0;
                    zero_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else if (exp_q <= 8'd1) begin
                    // Exponent would hit 0 while still unnormalized: flush to +0.
                    result_d    = '0;
                    overflow_d  = 1'b0;
                    zero_d      = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    sum_d = {sum_q[23:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sign_q      <= 1'b0;
            sign_men_q  <= 1'b0;
            exp_q       <= '0;
            diff_q      <= '0;
            mant_may_q  <= '0;
            mant_men_q  <= '0;
            sum_q       <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sign_q      <= sign_d;
            sign_men_q  <= sign_men_d;
            exp_q       <= exp_d;
            diff_q      <= diff_d;
            mant_may_q  <= mant_may_d;
            mant_men_q  <= mant_men_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: vector table with scoreboard, plus
// backpressure and mid-operation reset sequences.
module tb_fp_add_seq;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        ovf;
        logic        zro;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    vec_t vecs[10];
    vec_t sb[$];

    fp_add_seq_if bus_if ();

    fp_add_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Launch one operation; returns the cycle index of the acceptance edge.
    task automatic launch(input vec_t v, output int e0);
        int n;
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({v.name, " in_ready before launch"}, {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.a        = v.a;
        bus_if.b        = v.b;
        bus_if.sub      = v.sub;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus_if.in_valid = 1'b0;
        bus_if.a        = 32'hDEAD_BEEF;
        bus_if.b        = 32'hDEAD_BEEF;
        check({v.name, " busy after accept"}, {31'd0, bus_if.busy}, 32'd1);
    endtask

    // Wait (bounded) for out_valid; returns cycles since acceptance, -1 on timeout.
    task automatic wait_out(input int e0, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < 60) begin
            if (bus_if.out_valid === 1'b1) begin
                lat = cyc - e0;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic compare_out(input vec_t v, input int lat);
        check({v.name, " latency"}, lat, v.lat);
        check({v.name, " result"}, bus_if.result, v.res);
        check({v.name, " overflow"}, {31'd0, bus_if.overflow}, {31'd0, v.ovf});
        check({v.name, " zero"}, {31'd0, bus_if.zero}, {31'd0, v.zro});
    endtask

    task automatic run_vec(input vec_t v);
        int   e0;
        int   lat;
        vec_t exp_v;
        launch(v, e0);
        sb.push_back(v);
        wait_out(e0, lat);
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no out_valid required=out_valid", v.name);
            void'(sb.pop_front());
        end else begin
            exp_v = sb.pop_front();
            compare_out(exp_v, lat);
        end
        // out_ready is high, so this edge completes the handshake.
        @(posedge clk);
        #1;
        check({v.name, " in_ready after handshake"}, {31'd0, bus_if.in_ready}, 32'd1);
        check({v.name, " out_valid after handshake"}, {31'd0, bus_if.out_valid}, 32'd0);
    endtask

    initial begin
        int   e0;
        int   lat;
        vec_t v;

        vecs[0] = '{"1+1",        32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 4};
        vecs[1] = '{"1-1",        32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 3};
        vecs[2] = '{"1.5+tiny",   32'h3FC0_0000, 32'h3080_0000, 1'b0, 32'h3FC0_0000, 1'b0, 1'b0, 4};
        vecs[3] = '{"1-0.9999",   32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3400_0000, 1'b0, 1'b0, 27};
        vecs[4] = '{"overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 4};
        vecs[5] = '{"special a",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 1};
        vecs[6] = '{"1+2",        32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 4};
        vecs[7] = '{"2-3",        32'h4000_0000, 32'h4040_0000, 1'b1, 32'hBF80_0000, 1'b0, 1'b0, 5};
        vecs[8] = '{"0+1",        32'h0000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 4};
        vecs[9] = '{"special b",  32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 1};

        cyc              = 0;
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.sub       = 1'b0;
        bus_if.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("reset out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("reset busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset result", bus_if.result, 32'd0);
        check("reset flags", {30'd0, bus_if.overflow, bus_if.zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held while out_ready is low, new operands ignored.
        bus_if.out_ready = 1'b0;
        launch(vecs[0], e0);
        wait_out(e0, lat);
        check("bp latency", lat, 4);
        bus_if.a        = 32'h4040_0000;
        bus_if.b        = 32'h4040_0000;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid held", {31'd0, bus_if.out_valid}, 32'd1);
            check("bp result held", bus_if.result, 32'h4000_0000);
            check("bp in_ready low", {31'd0, bus_if.in_ready}, 32'd0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp no extra op", {31'd0, bus_if.busy}, 32'd0);

        // Asynchronous reset in the middle of a long normalization.
        launch(vecs[3], e0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst mid out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst mid in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst mid busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst mid result", bus_if.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst release in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst release out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst abandoned", sb.size(), 0);

        v = vecs[6];
        v.name = "after reset 1+2";
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
